// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Instruction-side driver for a combinational 16-bit ALU. Accepts one
//   instruction per handshake and reads operands from an 8-entry register
//   file, or takes a sign-extended immediate. Drives the ALU, captures its
//   result, writes it back and offers it on a result handshake. A new
//   instruction can be accepted at most once every three cycles
//   (IDLE -> EXEC -> RESP).
//
//   Instruction word: [15:12] opcode, [11:9] rd, [8] I.
//     I=1: [7:0] imm8.
//     I=0: [7:5] rs; [4:0] ignored.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     instruction handshake; instr is the instruction word
//   op_a, op_b, alu_func  ALU drive, held between instructions
//   alu_out               combinational ALU result
//   res_valid/ready       result handshake
//   res_data, res_rd      result value and its destination register
//   res_illegal           opcode unsupported; no writeback, res_data is 0
//   dbg_addr, dbg_data    combinational register-file read port
//
// Build option
//   ALU_ISSUE_FLAGS_EN    adds res_zero / res_neg result flags
module alu_issue_ctrl #(
   parameter int unsigned DW    = 16,
   parameter int unsigned IMM_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   output logic [DW-1:0] op_a,
   output logic [DW-1:0] op_b,
   output logic [3:0]    alu_func,
   input  logic [DW-1:0] alu_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [DW-1:0] res_data,
   output logic [2:0]    res_rd,
   output logic          res_illegal,
   input  logic [2:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
   ,
   output logic          res_zero,
   output logic          res_neg
`endif
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t        state_q;
   logic [2:0]    rd_q;
   // Entry 0 is never written, so it keeps its reset value and reads as zero.
   logic [DW-1:0] rf_q [8];

   logic [DW-1:0] rd_val;
   logic [DW-1:0] rs_val;
   logic [DW-1:0] imm_ext;
   logic          legal;

   always_comb begin
      rd_val  = rf_q[instr[11:9]];
      rs_val  = rf_q[instr[7:5]];
      imm_ext = {{(DW-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
   end

   // alu_func holds the latched opcode for the whole EXEC cycle.
   always_comb begin
      unique case (alu_func)
         4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010: legal = 1'b1;
         default:                                     legal = 1'b0;
      endcase
   end

   assign dbg_data = rf_q[dbg_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rd_q        <= '0;
         instr_ready <= 1'b1;
         op_a        <= '0;
         op_b        <= '0;
         alu_func    <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_rd      <= '0;
         res_illegal <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
         res_zero    <= 1'b0;
         res_neg     <= 1'b0;
`endif
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (instr_valid) begin
                  // Operands are loaded at the accept edge. The previous
                  // writeback has already landed, and nothing else can write
                  // the file before EXEC, so the EXEC-cycle values match.
                  op_a        <= rd_val;
                  op_b        <= instr[8] ? imm_ext : rs_val;
                  alu_func    <= instr[15:12];
                  rd_q        <= instr[11:9];
                  instr_ready <= 1'b0;
                  state_q     <= StExec;
               end
            end
            StExec: begin
               res_rd    <= rd_q;
               res_valid <= 1'b1;
               state_q   <= StResp;
               if (legal) begin
                  res_data    <= alu_out;
                  res_illegal <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
                  res_zero    <= (alu_out == '0);
                  res_neg     <= alu_out[DW-1];
`endif
                  if (rd_q != 3'd0) begin
                     rf_q[rd_q] <= alu_out;
                  end
               end else begin
                  res_data    <= '0;
                  res_illegal <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                  res_zero    <= 1'b0;
                  res_neg     <= 1'b0;
`endif
               end
            end
            StResp: begin
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  instr_ready <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [15:0]   instr = '0;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [3:0]    alu_func;
   logic [DW-1:0] alu_out;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [DW-1:0] res_data;
   logic [2:0]    res_rd;
   logic          res_illegal;
   logic [2:0]    dbg_addr = '0;
   logic [DW-1:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
   logic          res_zero;
   logic          res_neg;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference register file: plain array of values, r0 stays zero.
   logic [15:0] m_rf [8];

   always #5 clk = ~clk;

   // Environment ALU: arbitrary but fixed function per opcode.
   function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
      case (f)
         4'b0010: return a + b;
         4'b0100: return a - b;
         4'b0110: return a & b;
         4'b1000: return a | b;
         4'b1010: return a ^ b;
         default: return ~(a + b);
      endcase
   endfunction

   assign alu_out = alu_ref(op_a, op_b, alu_func);

   alu_issue_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .op_a        (op_a),
      .op_b        (op_b),
      .alu_func    (alu_func),
      .alu_out     (alu_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .res_illegal (res_illegal),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
      ,
      .res_zero    (res_zero),
      .res_neg     (res_neg)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rf(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check(tag, dbg_data, m_rf[i]);
      end
   endtask

   // One full transaction: accept, EXEC checks, result checks with an
   // optional back-pressure stall, then release.
   task automatic run_instr(input logic [15:0] ins, input int stall);
      logic [3:0]  opc;
      logic [2:0]  rd;
      logic [2:0]  rs;
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      logic [15:0] exp_res;
      bit          is_legal;
      int          imm;

      opc = ins[15:12];
      rd  = ins[11:9];
      rs  = ins[7:5];
      imm = int'(ins[7:0]);
      is_legal = (opc == 4'd2) || (opc == 4'd4) || (opc == 4'd6) ||
                 (opc == 4'd8) || (opc == 4'd10);
      exp_a = m_rf[rd];
      if (ins[8]) exp_b = (imm >= 128) ? 16'(imm + 65280) : 16'(imm);
      else        exp_b = m_rf[rs];
      exp_res = is_legal ? alu_ref(exp_a, exp_b, opc) : 16'h0000;

      check("ready_idle", instr_ready, 1);
      instr       = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      check("exec_ready", instr_ready, 0);
      check("exec_valid", res_valid, 0);
      check("exec_op_a", op_a, exp_a);
      check("exec_op_b", op_b, exp_b);
      check("exec_func", alu_func, opc);
      tick();
      check("resp_valid", res_valid, 1);
      check("resp_data", res_data, exp_res);
      check("resp_rd", res_rd, rd);
      check("resp_illegal", res_illegal, !is_legal);
`ifdef ALU_ISSUE_FLAGS_EN
      check("resp_zero", res_zero, is_legal && exp_res == 16'h0);
      check("resp_neg", res_neg, is_legal && exp_res >= 16'h8000);
`endif
      if (is_legal && rd != 3'd0) m_rf[rd] = exp_res;
      dbg_addr = rd;
      #1;
      check("dbg_wb", dbg_data, m_rf[rd]);
      for (int s = 0; s < stall; s++) begin
         instr_valid = 1'($urandom);
         instr       = 16'($urandom);
         tick();
         check("stall_valid", res_valid, 1);
         check("stall_data", res_data, exp_res);
         check("stall_rd", res_rd, rd);
         check("stall_ready", instr_ready, 0);
      end
      instr_valid = 1'b0;
      res_ready   = 1'b1;
      tick();
      res_ready = 1'b0;
      check("done_valid", res_valid, 0);
      check("done_ready", instr_ready, 1);
      check("hold_op_a", op_a, exp_a);
      check("hold_func", alu_func, opc);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]  legal_ops [5];
      logic [15:0] ins;
      legal_ops = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
      for (int i = 0; i < 8; i++) m_rf[i] = '0;

      // Reset state
      #12;
      check("rst_valid", res_valid, 0);
      check("rst_data", res_data, 0);
      check("rst_illegal", res_illegal, 0);
      check("rst_op_a", op_a, 0);
      check("rst_op_b", op_b, 0);
      check("rst_func", alu_func, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_ready", instr_ready, 1);
      check_rf("rst_rf");

      // res_ready while idle does nothing
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("idle_rr_valid", res_valid, 0);
      check("idle_rr_ready", instr_ready, 1);

      // Directed sequence
      run_instr(16'h2301, 0);  // r1 = r1 + 1
      run_instr(16'h4584, 0);  // r2 = r2 - 0xFF84
      run_instr(16'h6620, 0);  // r3 = r3 & r1
      run_instr(16'h3301, 0);  // illegal, r1 untouched
      run_instr(16'h8301, 5);  // back-pressure with ignored instr_valid
      run_instr(16'h2105, 0);  // write to r0 discarded
      check_rf("directed_rf");

      // Randomised traffic
      for (int n = 0; n < 60; n++) begin
         ins = 16'($urandom);
         if ($urandom_range(0, 4) != 0) ins[15:12] = legal_ops[$urandom_range(0, 4)];
         run_instr(ins, int'($urandom_range(0, 3)));
      end
      check_rf("random_rf");

      // Reset during EXEC discards the result
      run_instr(16'h2F7F, 0);
      instr       = 16'h2F01;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      check("pre_rst_exec", instr_ready, 0);
      rst_n = 1'b0;
      #2;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_op_a", op_a, 0);
      check("mid_rst_func", alu_func, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", res_valid, 0);
      check("post_rst_ready", instr_ready, 1);
      check_rf("post_rst_rf");
      run_instr(16'hA3FF, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
